// File: rtl/deco_pkg.sv
// Shared types and constants for the encoded-code FIFO with one-hot decode.
package deco_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_e;

    typedef struct packed {
        logic              zero;
        logic [CODE_W-1:0] code;
    } entry_t;

endpackage

// File: rtl/deco_core.sv
// Combinational 3:8 decoder; zero_force blanks the whole word.
module deco_core
    import deco_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    input  logic                zero_force,
    output logic [ONEHOT_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (!zero_force) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/deco_fifo_dut.sv
// Circular buffer of encoder codes, decoded to one-hot at the head on the way out.
// Handshake: a word moves on any rising edge where valid && ready; valid never waits on ready.
module deco_fifo_dut
    import deco_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_code,
    input  logic                         in_zero,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_onehot,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [7:0]                   zero_cnt,
    output logic [1:0]                   state_dbg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(DEPTH - 1);

    fifo_state_e      state;
    fifo_state_e      state_nxt;
    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic [7:0]       zero_cnt_q;
    logic             push;
    logic             pop;

    always_comb begin
        state_nxt = state;
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        unique case (state)
            EMPTY: begin
                if (push) state_nxt = PARTIAL;
            end
            PARTIAL: begin
                if (push && !pop && level_q == LVL_LAST) begin
                    state_nxt = FULL;
                end else if (pop && !push && level_q == LVL_ONE) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) state_nxt = PARTIAL;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            zero_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LVL_W'(1);
            end
            if (push && in_zero && zero_cnt_q != 8'hFF) begin
                zero_cnt_q <= zero_cnt_q + 8'd1;
            end
        end
    end

    // Storage is left unreset; it is only read while the buffer holds entries.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= '{zero: in_zero, code: in_code};
        end
    end

    assign head = mem[rd_ptr];

    deco_core u_deco_core (
        .code       (head.code),
        .zero_force (head.zero || !out_valid),
        .onehot     (out_onehot)
    );

    assign level     = level_q;
    assign zero_cnt  = zero_cnt_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_deco_fifo_dut.sv
// Directed bench for deco_fifo_dut: driver queues expected words, a negedge monitor checks them.
module tb_deco_fifo_dut;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       in_zero;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_onehot;
    logic [2:0] level;
    logic [7:0] zero_cnt;
    logic [1:0] state_dbg;

    logic [7:0] exp_q[$];
    int         checks;
    int         errors;
    logic       prev_hold;
    logic [7:0] prev_word;

    deco_fifo_dut #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_zero    (in_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .level      (level),
        .zero_cnt   (zero_cnt),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_word(input logic z, input logic [2:0] c);
        logic [7:0] one;
        one = 8'h01;
        return z ? 8'h00 : (one << c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: one cycle of stimulus; expected word queued when the push will be taken
    task automatic drive(input logic v, input logic z, input logic [2:0] c, input logic r);
        in_valid  = v;
        in_zero   = z;
        in_code   = c;
        out_ready = r;
        if (v && in_ready && rst_n) exp_q.push_back(exp_word(z, c));
        tick();
    endtask

    task automatic idle(input logic r);
        drive(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), r);
    endtask

    // monitor: compares each delivered word and the hold-stable rule
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_word", 32'(out_onehot), 32'(prev_word));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none at %0t", out_onehot, $time);
                end else begin
                    check("out_word", 32'(out_onehot), 32'(exp_q.pop_front()));
                end
            end
            if (!out_valid) check("idle_onehot", 32'(out_onehot), 32'h00);
            prev_hold = out_valid && !out_ready;
            prev_word = out_onehot;
        end
    end

    initial begin
        #2000000;
        checks++;
        errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        checks    = 0;
        errors    = 0;
        prev_hold = 1'b0;
        prev_word = 8'h00;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_zero   = 1'b0;
        in_code   = 3'd0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_onehot", 32'(out_onehot), 32'h00);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_zero_cnt", 32'(zero_cnt), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);

        // single transfer, code 5; no bypass in the push cycle
        in_valid  = 1'b1;
        in_zero   = 1'b0;
        in_code   = 3'd5;
        out_ready = 1'b1;
        #1;
        check("no_bypass_valid", 32'(out_valid), 32'd0);
        exp_q.push_back(exp_word(1'b0, 3'd5));
        tick();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_onehot", 32'(out_onehot), 32'h20);
        check("t1_level", 32'(level), 32'd1);
        check("t1_state", 32'(state_dbg), 32'd1);
        idle(1'b1);
        check("t1_level_after", 32'(level), 32'd0);
        check("t1_valid_after", 32'(out_valid), 32'd0);

        // fill to full, then an ignored fifth push
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 3'(i), 1'b0);
        check("full_level", 32'(level), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_state", 32'(state_dbg), 32'd2);
        check("full_head", 32'(out_onehot), 32'h01);
        drive(1'b1, 1'b0, 3'd7, 1'b0);
        check("full_level_hold", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("drain_level", 32'(level), 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);

        // zero entry
        drive(1'b1, 1'b1, 3'd6, 1'b0);
        check("zero_valid", 32'(out_valid), 32'd1);
        check("zero_onehot", 32'(out_onehot), 32'h00);
        check("zero_cnt_1", 32'(zero_cnt), 32'd1);
        idle(1'b1);
        check("zero_drained", 32'(level), 32'd0);

        // steady push+pop at level 2 across pointer wrap
        drive(1'b1, 1'b0, 3'd1, 1'b0);
        drive(1'b1, 1'b0, 3'd2, 1'b0);
        check("pp_level_start", 32'(level), 32'd2);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'(i == 4), 3'((i + 3) % 8), 1'b1);
            check("pp_level", 32'(level), 32'd2);
        end
        check("pp_zero_cnt", 32'(zero_cnt), 32'd2);
        idle(1'b1);
        idle(1'b1);
        check("pp_empty", 32'(level), 32'd0);
        check("pp_queue", 32'(exp_q.size()), 32'd0);

        // reset mid-operation with push and pop presented in the reset cycle
        drive(1'b1, 1'b0, 3'd3, 1'b0);
        drive(1'b1, 1'b1, 3'd4, 1'b0);
        drive(1'b1, 1'b0, 3'd7, 1'b0);
        check("mid_level", 32'(level), 32'd3);
        rst_n = 1'b0;
        exp_q.delete();
        drive(1'b1, 1'b0, 3'd2, 1'b1);
        rst_n = 1'b1;
        in_valid = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_zero_cnt", 32'(zero_cnt), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("mid_rst_still_empty", 32'(out_valid), 32'd0);

        // zero_cnt saturation
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'b1);
            if (i == 253) check("sat_254", 32'(zero_cnt), 32'hFE);
            if (i == 254) check("sat_255", 32'(zero_cnt), 32'hFF);
        end
        check("sat_300", 32'(zero_cnt), 32'hFF);
        idle(1'b1);
        idle(1'b1);
        check("final_level", 32'(level), 32'd0);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
